// File: rtl/i2c_pkg.sv
// Shared I2C definitions: state encoding (common with i2c_master for
// waveform debug), bus field widths and ACK/NACK line levels.
package i2c_pkg;
    localparam int   ADDR_W = 7;
    localparam int   DATA_W = 8;
    localparam logic ACK    = 1'b0;
    localparam logic NACK   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        WAIT_STOP
    } i2c_state_e;
endpackage

// File: rtl/i2c_slave_if.sv
// User-side port of the I2C target: transmit byte supply, received byte
// strobe and transfer status.
interface i2c_slave_if;
    import i2c_pkg::*;

    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              addr_hit;
    logic              rw_out;
    logic              busy;

    modport slave  (input tx_data,
                    output tx_load, rx_data, rx_valid, addr_hit, rw_out, busy);
    modport master (output tx_data,
                    input tx_load, rx_data, rx_valid, addr_hit, rw_out, busy);
endinterface

// File: rtl/i2c_line_cond.sv
// Per-line conditioner: synchronizer, optional 3-sample majority filter
// (I2C_SLAVE_GLITCH_FILTER_EN) and registered rise/fall detection.
// Lines reset to 1 because the bus idles high.
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   cond;
    logic                   prev;

    // Metastability chain on the asynchronous bus line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '1;
        else       sync <= {sync[SYNC_STAGES-2:0], din};
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       filt;
    logic       s;

    assign s = sync[SYNC_STAGES-1];

    // Majority of the current and two previous samples; rejects 1-clk pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= 2'b11;
            filt <= 1'b1;
        end else begin
            hist <= {hist[0], s};
            filt <= (s & hist[0]) | (s & hist[1]) | (hist[0] & hist[1]);
        end
    end

    assign cond = filt;
`else
    assign cond = sync[SYNC_STAGES-1];
`endif

    // Previous conditioned value for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= 1'b1;
        else       prev <= cond;
    end

    assign level = cond;
    assign rise  = cond & ~prev;
    assign fall  = ~cond & prev;
endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, byte receive with rx_valid strobe and
// byte transmit from tx_data. SDA is open drain (0 or z) and only changes
// after a detected SCL fall. Optional input filter: I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h67,
    parameter int                SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl,
    inout  wire           sda,
    i2c_slave_if.slave    bus
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_state_e        state;
    logic [3:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] tx_shreg;
    logic              sda_oe;
    logic              master_ack;

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .reset(reset), .din(scl),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .reset(reset), .din(sda),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign sda       = sda_oe ? 1'b0 : 1'bz;

    // Protocol FSM: START/STOP take priority over bit handling; outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            tx_shreg     <= '0;
            sda_oe       <= 1'b0;
            master_ack   <= NACK;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            bus.tx_load  <= 1'b0;
            bus.addr_hit <= 1'b0;
            bus.rw_out   <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            bus.tx_load  <= 1'b0;
            if (start_det) begin
                state        <= ADDR;
                bit_cnt      <= '0;
                sda_oe       <= 1'b0;
                bus.addr_hit <= 1'b0;
                bus.busy     <= 1'b1;
            end else if (stop_det) begin
                state        <= IDLE;
                bit_cnt      <= '0;
                sda_oe       <= 1'b0;
                bus.addr_hit <= 1'b0;
                bus.busy     <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    ADDR: begin
                        shreg   <= {shreg[DATA_W-2:0], sda_lvl};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    WRITE: begin
                        shreg   <= {shreg[DATA_W-2:0], sda_lvl};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bus.rx_data  <= {shreg[DATA_W-2:0], sda_lvl};
                            bus.rx_valid <= 1'b1;
                        end
                    end
                    READ_ACK: master_ack <= sda_lvl;
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    ADDR: begin
                        if (bit_cnt == 4'd8) begin
                            if (shreg[DATA_W-1:1] == SLAVE_ADDR) begin
                                sda_oe       <= 1'b1;
                                bus.rw_out   <= shreg[0];
                                bus.addr_hit <= 1'b1;
                                state        <= ADDR_ACK;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (bus.rw_out) begin
                            bus.tx_load <= 1'b1;
                            tx_shreg    <= bus.tx_data;
                            sda_oe      <= ~bus.tx_data[DATA_W-1];
                            bit_cnt     <= 4'd1;
                            state       <= READ;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe <= 1'b1;
                            state  <= WRITE_ACK;
                        end
                    end
                    WRITE_ACK: begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= WRITE;
                    end
                    READ: begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            state  <= READ_ACK;
                        end else begin
                            sda_oe   <= ~tx_shreg[DATA_W-2];
                            tx_shreg <= tx_shreg << 1;
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end
                    READ_ACK: begin
                        if (master_ack == ACK) begin
                            bus.tx_load <= 1'b1;
                            tx_shreg    <= bus.tx_data;
                            sda_oe      <= ~bus.tx_data[DATA_W-1];
                            bit_cnt     <= 4'd1;
                            state       <= READ;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
